status_register_unit: RTL
=========================

STATUS_REGISTER_UNIT -- requirements
Module: status_register_unit

Interface
REQ-001 Clk  input  1  rising-edge clock for all state.
REQ-002 Reset  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-003 ALU_Result  input  32  result of the current data-processing operation.
REQ-004 ALU_Cout  input  1  ALU carry-out; for subtract-type operations this is NOT borrow.
REQ-005 Shifter_Cout  input  1  shifter carry-out, used for logical operations.
REQ-006 Op_A31, Op_B31  input  1 each  sign bits of ALU operands A (Rn) and B (shifter operand).
REQ-007 ALU_Op  input  4  data-processing opcode, IR[24:21].
REQ-008 S_Bit  input  1  set-flags bit, IR[20].
REQ-009 Cond_Pass  input  1  condition-test result for the current instruction.
REQ-010 Valid  input  1  instruction in this stage is real, not a bubble.
REQ-011 Stall  input  1  pipeline hold.
REQ-012 Flag_We  input  1  direct flag write, MSR-style.
REQ-013 Flag_In  input  4  direct write value, {N,Z,C,V}.
REQ-014 N_, Zero_, C_, V_  output  1 each  registered flags, sized to drive a condition tester.
REQ-015 N_nx, Zero_nx, C_nx, V_nx  output  1 each  combinational next-flag bypass values.
REQ-016 Flags_Updated  output  1  registered one-cycle pulse marking a flag change.

Function
REQ-017 Opcode classes are fixed:
- Logical: AND 0000, EOR 0001, TST 1000, TEQ 1001, ORR 1100, MOV 1101, BIC 1110, MVN 1111.
- Add-type: ADD 0100, ADC 0101, CMN 1011.
- Sub-type: SUB 0010, SBC 0110, CMP 1010.
- Reverse-sub: RSB 0011, RSC 0111.
REQ-018 Computed N SHALL be ALU_Result[31].
REQ-019 Computed Z SHALL be 1 iff ALU_Result == 32'h0000_0000.
REQ-020 Computed C SHALL be Shifter_Cout for logical ops and ALU_Cout for all other ops.
REQ-021 Computed V SHALL be:
- add-type: (A31==B31) & (R31!=A31).
- sub-type: (A31!=B31) & (R31!=A31).
- reverse-sub: (A31!=B31) & (R31!=B31).
- logical: current V_ unchanged.
REQ-022 Alu_Upd = Valid & S_Bit & Cond_Pass & ~Stall.
REQ-023 Dir_Upd = Flag_We & ~Stall.
REQ-024 On a rising Clk with Dir_Upd=1, the flags SHALL load Flag_In; Dir_Upd has priority over Alu_Upd.
REQ-025 On a rising Clk with Dir_Upd=0 and Alu_Upd=1, the flags SHALL load the computed NZCV.
REQ-026 Otherwise the flags SHALL hold, including whenever Stall=1, regardless of other inputs.
REQ-027 Latency: one cycle from the update-enable edge to visibility on N_/Zero_/C_/V_.
REQ-028 *_nx outputs SHALL equal the value the flags take on the next edge, or the current flags when no update is enabled; they are purely combinational.
REQ-029 Flags_Updated SHALL be 1 for exactly the cycle after any edge where Dir_Upd or Alu_Upd was 1, even if the flag values did not change.
REQ-030 Back-to-back updates SHALL each take effect on consecutive edges; there is no dead cycle.
REQ-031 Valid=0 or Cond_Pass=0 SHALL suppress the ALU update with no side effect.

Reset
REQ-032 While Reset=1 at a rising Clk: N_, Zero_, C_, V_ and Flags_Updated SHALL all become 0; Reset overrides Stall, Flag_We and Alu_Upd.
REQ-033 The first update SHALL be accepted on the first edge after Reset deasserts.
REQ-034 A reset arriving mid-stream SHALL discard any update presented on that same edge.

Verification
REQ-035 ADD case:
- Stimulus: ALU_Op=0100, S=1, Cond_Pass=1, Valid=1, R=32'h8000_0000, A31=0, B31=0, ALU_Cout=0.
- Required next cycle: N=1, Z=0, C=0, V=1, Flags_Updated=1.
REQ-036 CMP case:
- Stimulus: ALU_Op=1010, R=0, ALU_Cout=1, A31=B31=0.
- Required: N=0, Z=1, C=1, V=0.
REQ-037 MOV case:
- Stimulus: prior V_=1; ALU_Op=1101, R=32'hFFFF_FFFF, Shifter_Cout=1.
- Required: N=1, Z=0, C=1, V stays 1.
REQ-038 Suppression case:
- Stimulus: S=0, or Cond_Pass=0, or Valid=0, or Stall=1, with any result presented.
- Required: flags unchanged, Flags_Updated=0, *_nx equals current flags.
REQ-039 Priority case:
- Stimulus: Flag_We=1 with Flag_In=4'b0110, and a simultaneous valid ADD update.
- Required: flags become N=0, Z=1, C=1, V=0.
REQ-040 Reset case:
- Stimulus: Reset=1 with flags 4'b1111 and Flag_We=1.
- Required: flags all 0 and Flags_Updated=0 next cycle; an update on the first post-reset edge is visible one cycle later.

Source files
------------

// File: rtl/status_register_unit.sv
// ---------------------------------------------------------------------------
// status_register_unit
//
// Holds the NZCV condition flags of the integer pipeline. Each cycle the
// unit derives candidate flags from the ALU/shifter results of the current
// data-processing instruction. It then commits either those flags or a
// direct (MSR-style) write value, and signals every commit with a one-cycle
// pulse.
//
// Ports
//   Clk            in   rising-edge clock
//   Reset          in   synchronous active-high reset
//   ALU_Result     in   [31:0] result of the current operation
//   ALU_Cout       in   ALU carry-out (NOT borrow for subtracts)
//   Shifter_Cout   in   shifter carry-out, used by logical ops
//   Op_A31/Op_B31  in   sign bits of operand A (Rn) and B (shifter operand)
//   ALU_Op         in   [3:0] data-processing opcode
//   S_Bit          in   set-flags bit
//   Cond_Pass      in   condition test passed
//   Valid          in   stage holds a real instruction
//   Stall          in   pipeline hold; freezes the flags
//   Flag_We        in   direct flag write enable
//   Flag_In        in   [3:0] direct write value {N,Z,C,V}
//   N_/Zero_/C_/V_ out  registered flags
//   *_nx           out  combinational value the flags take on the next edge
//   Flags_Updated  out  registered pulse, high the cycle after any commit
// ---------------------------------------------------------------------------
module status_register_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] ALU_Result,
    input  logic        ALU_Cout,
    input  logic        Shifter_Cout,
    input  logic        Op_A31,
    input  logic        Op_B31,
    input  logic [3:0]  ALU_Op,
    input  logic        S_Bit,
    input  logic        Cond_Pass,
    input  logic        Valid,
    input  logic        Stall,
    input  logic        Flag_We,
    input  logic [3:0]  Flag_In,
    output logic        N_,
    output logic        Zero_,
    output logic        C_,
    output logic        V_,
    output logic        N_nx,
    output logic        Zero_nx,
    output logic        C_nx,
    output logic        V_nx,
    output logic        Flags_Updated
);

    typedef enum logic [1:0] {
        CLS_LOGIC = 2'd0,
        CLS_ADD   = 2'd1,
        CLS_SUB   = 2'd2,
        CLS_RSUB  = 2'd3
    } op_class_e;

    // Opcode to flag-class mapping. All sixteen encodings are covered; the
    // default arm collects the eight logical opcodes.
    function automatic op_class_e classify(input logic [3:0] op);
        op_class_e cls;
        case (op)
            4'b0100, 4'b0101, 4'b1011: cls = CLS_ADD;   // ADD ADC CMN
            4'b0010, 4'b0110, 4'b1010: cls = CLS_SUB;   // SUB SBC CMP
            4'b0011, 4'b0111:          cls = CLS_RSUB;  // RSB RSC
            default:                   cls = CLS_LOGIC; // AND EOR TST TEQ ORR MOV BIC MVN
        endcase
        return cls;
    endfunction

    // Signed overflow from operand/result sign bits. For reverse subtracts
    // the minuend is B, so the result sign is compared against B.
    function automatic logic overflow(input op_class_e cls,
                                      input logic      a31,
                                      input logic      b31,
                                      input logic      r31,
                                      input logic      v_cur);
        logic v;
        case (cls)
            CLS_ADD:  v = (a31 == b31) && (r31 != a31);
            CLS_SUB:  v = (a31 != b31) && (r31 != a31);
            CLS_RSUB: v = (a31 != b31) && (r31 != b31);
            default:  v = v_cur;
        endcase
        return v;
    endfunction

    // Flag vector packing is {N,Z,C,V} throughout.
    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       upd_q;
    logic       upd_d;

    op_class_e  op_cls;
    logic [3:0] alu_flags;
    logic       alu_upd;
    logic       dir_upd;

    assign op_cls  = classify(ALU_Op);
    assign alu_upd = Valid & S_Bit & Cond_Pass & ~Stall;
    assign dir_upd = Flag_We & ~Stall;

    always_comb begin
        alu_flags[3] = ALU_Result[31];
        alu_flags[2] = (ALU_Result == 32'h0000_0000);
        alu_flags[1] = (op_cls == CLS_LOGIC) ? Shifter_Cout : ALU_Cout;
        alu_flags[0] = overflow(op_cls, Op_A31, Op_B31, ALU_Result[31], flags_q[0]);
    end

    // Direct write wins over an ALU update; with neither, the flags hold.
    always_comb begin
        flags_d = flags_q;
        upd_d   = 1'b0;
        if (dir_upd) begin
            flags_d = Flag_In;
            upd_d   = 1'b1;
        end else if (alu_upd) begin
            flags_d = alu_flags;
            upd_d   = 1'b1;
        end
    end

    // Reset discards whatever commit is presented on the same edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            flags_q <= 4'b0000;
            upd_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            upd_q   <= upd_d;
        end
    end

    assign N_            = flags_q[3];
    assign Zero_         = flags_q[2];
    assign C_            = flags_q[1];
    assign V_            = flags_q[0];
    assign N_nx          = flags_d[3];
    assign Zero_nx       = flags_d[2];
    assign C_nx          = flags_d[1];
    assign V_nx          = flags_d[0];
    assign Flags_Updated = upd_q;

endmodule
